// File: rtl/alu_result_stage.sv
// Registered result stage behind the ripple-carry ALU: flags computed at push,
// small circular FIFO with valid/ready on both sides, sticky carry and pop counter.
module alu_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] f_i,
  input  logic             cout_i,
  input  logic [3:0]       sel_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_f_o,
  output logic             out_cout_o,
  output logic [3:0]       out_sel_o,
  output logic             out_zero_o,
  output logic             out_neg_o,
  output logic             sticky_cout_o,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_f    [DEPTH];
  logic             mem_cout [DEPTH];
  logic [3:0]       mem_sel  [DEPTH];
  logic             mem_zero [DEPTH];
  logic             mem_neg  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             full;
  logic             push;
  logic             pop;

  assign full        = (occ == OCC_W'(DEPTH));
  assign in_ready_o  = rst_ni && !full;
  assign out_valid_o = (occ != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      sticky_cout_o <= 1'b0;
      count_o       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      if (clr_i) begin
        sticky_cout_o <= 1'b0;
        count_o       <= '0;
      end else begin
        if (push && cout_i) sticky_cout_o <= 1'b1;
        if (pop && (count_o != '1)) count_o <= count_o + CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: push is already blocked while rst_ni is low.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_f[wr_ptr]    <= f_i;
      mem_cout[wr_ptr] <= cout_i;
      mem_sel[wr_ptr]  <= sel_i;
      mem_zero[wr_ptr] <= (f_i == '0);
      mem_neg[wr_ptr]  <= f_i[WIDTH-1];
    end
  end

  // Head fields are masked to zero when empty so the post-reset view is defined.
  always_comb begin
    out_f_o    = '0;
    out_cout_o = 1'b0;
    out_sel_o  = '0;
    out_zero_o = 1'b0;
    out_neg_o  = 1'b0;
    if (out_valid_o) begin
      out_f_o    = mem_f[rd_ptr];
      out_cout_o = mem_cout[rd_ptr];
      out_sel_o  = mem_sel[rd_ptr];
      out_zero_o = mem_zero[rd_ptr];
      out_neg_o  = mem_neg[rd_ptr];
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, clr;
  logic [31:0] f;
  logic        cout;
  logic [3:0]  sel;
  logic [31:0] out_f;
  logic        out_cout, out_zero, out_neg, sticky;
  logic [3:0]  out_sel;
  logic [15:0] count;

  logic        s_in_ready, s_out_valid, s_out_cout, s_out_zero, s_out_neg, s_sticky;
  logic [31:0] s_out_f;
  logic [3:0]  s_out_sel;
  logic [3:0]  s_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .f_i(f), .cout_i(cout), .sel_i(sel), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_f_o(out_f), .out_cout_o(out_cout), .out_sel_o(out_sel), .out_zero_o(out_zero),
    .out_neg_o(out_neg), .sticky_cout_o(sticky), .clr_i(clr), .count_o(count)
  );

  alu_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_W(4)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
    .f_i(f), .cout_i(cout), .sel_i(sel), .out_valid_o(s_out_valid), .out_ready_i(out_ready),
    .out_f_o(s_out_f), .out_cout_o(s_out_cout), .out_sel_o(s_out_sel), .out_zero_o(s_out_zero),
    .out_neg_o(s_out_neg), .sticky_cout_o(s_sticky), .clr_i(clr), .count_o(s_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Reference model: FIFO contents as a queue, counters as plain integers.
  typedef struct {
    logic [31:0] f;
    logic        c;
    logic [3:0]  s;
  } ent_t;

  ent_t mq[$];
  int   pops;
  bit   m_sticky;
  bit   clean;
  bit   started = 0;

  always @(posedge clk) begin
    bit do_push, do_pop;
    started = 1;
    if (!rst_n) begin
      mq.delete();
      pops     = 0;
      m_sticky = 0;
      clean    = 1;
    end else begin
      do_push = in_valid && (mq.size() < 2);
      do_pop  = (mq.size() > 0) && out_ready;
      if (do_pop) begin
        void'(mq.pop_front());
        pops++;
      end
      if (do_push) begin
        mq.push_back('{f: f, c: cout, s: sel});
        clean = 0;
      end
      if (clr) begin
        pops     = 0;
        m_sticky = 0;
      end else if (do_push && cout) begin
        m_sticky = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_in_ready", in_ready, rst_n && (mq.size() < 2));
      chk("m_out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("m_out_f", out_f, mq[0].f);
        chk("m_out_cout", out_cout, mq[0].c);
        chk("m_out_sel", out_sel, mq[0].s);
        chk("m_out_zero", out_zero, mq[0].f == 32'd0);
        chk("m_out_neg", out_neg, mq[0].f[31]);
        chk("m_sat_out_f", s_out_f, mq[0].f);
      end else if (clean) begin
        chk("m_reset_fields", {out_f, out_cout, out_sel, out_zero, out_neg}, '0);
      end
      chk("m_sticky", sticky, m_sticky);
      chk("m_count", count, (pops > 65535) ? 65535 : pops);
      chk("m_sat_count", s_count, (pops > 15) ? 15 : pops);
      chk("m_sat_ready", s_in_ready, in_ready);
      chk("m_sat_valid", s_out_valid, out_valid);
      chk("m_sat_misc", {s_out_cout, s_out_sel, s_out_zero, s_out_neg, s_sticky},
          {out_cout, out_sel, out_zero, out_neg, sticky});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 0; clr = 0; f = '0; cout = 0; sel = '0;
    tick();
    chk("rst_in_ready", in_ready, 0);
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_out_f", out_f, 0);
    rst_n = 1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Single push of a zero result with carry.
    in_valid = 1; f = 32'h0; cout = 1; sel = 4'h3; out_ready = 1;
    tick();
    in_valid = 0; cout = 0;
    chk("t1_valid", out_valid, 1);
    chk("t1_zero", out_zero, 1);
    chk("t1_neg", out_neg, 0);
    chk("t1_cout", out_cout, 1);
    chk("t1_sel", out_sel, 3);
    chk("t1_sticky", sticky, 1);
    chk("t1_count0", count, 0);
    tick();
    chk("t1_count1", count, 1);
    chk("t1_empty", out_valid, 0);

    // Fill with the consumer stalled, then drain in order.
    out_ready = 0; in_valid = 1; f = 32'h8000_0001; sel = 4'h1;
    tick();
    f = 32'h0000_0005; sel = 4'h2;
    tick();
    in_valid = 0;
    chk("t2_full", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      chk("t2_head", out_f, 32'h8000_0001);
      chk("t2_neg", out_neg, 1);
      tick();
    end
    out_ready = 1;
    tick();
    chk("t2_second", out_f, 32'h5);
    chk("t2_ready_back", in_ready, 1);
    tick();
    chk("t2_empty", out_valid, 0);
    chk("t2_count", count, 3);

    // Streaming, one push and one pop per cycle.
    for (int i = 0; i < 100; i++) begin
      in_valid = 1; f = i; sel = i[3:0];
      tick();
      chk("t3_valid", out_valid, 1);
      chk("t3_head", out_f, i);
    end
    in_valid = 0;
    tick();
    chk("t3_count", count, 103);

    // Full buffer with push attempt and pop in the same cycle.
    out_ready = 0; in_valid = 1; f = 32'h11;
    tick();
    f = 32'h22;
    tick();
    f = 32'h33; out_ready = 1;
    tick();
    chk("t4_head", out_f, 32'h22);
    chk("t4_ready", in_ready, 1);
    chk("t4_valid", out_valid, 1);
    tick();
    chk("t4_held_in", out_f, 32'h33);
    in_valid = 0;
    tick();
    chk("t4_empty", out_valid, 0);
    chk("t4_count", count, 106);

    // clr colliding with push-with-carry and pop.
    out_ready = 0; in_valid = 1; f = 32'h7; cout = 1;
    tick();
    chk("t5_sticky_set", sticky, 1);
    clr = 1; f = 32'h9; out_ready = 1;
    tick();
    clr = 0; in_valid = 0; cout = 0;
    chk("t5_sticky_clr", sticky, 0);
    chk("t5_count_clr", count, 0);
    chk("t5_intact", out_f, 32'h9);
    chk("t5_intact_c", out_cout, 1);
    tick();
    chk("t5_count1", count, 1);

    // Counter saturation on the narrow instance.
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; f = 200 + i;
      tick();
    end
    in_valid = 0;
    tick();
    chk("t6_sat", s_count, 15);
    chk("t6_wide", count, 21);

    // Reset with two entries buffered.
    out_ready = 0; in_valid = 1; f = 32'hA; cout = 1;
    tick();
    f = 32'hB;
    tick();
    in_valid = 0; cout = 0;
    chk("t6_full", in_ready, 0);
    rst_n = 0;
    #1;
    chk("t6_rst_ready", in_ready, 0);
    tick();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_sticky", sticky, 0);
    chk("t6_rst_f", out_f, 0);
    rst_n = 1; out_ready = 1;
    #1;
    chk("t6_rel_ready", in_ready, 1);
    tick();
    tick();
    chk("t6_no_pop", count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
